xor_chain_checker: RTL

- Self-checking harness stage for the XOR/invert primitive chain used in the correctness suite.
- Sits on both sides of the chain:
  - upstream, it drives the 2*IO_PAIRS-bit stimulus into the chain's input bus;
  - downstream, it samples the chain's output bus and compares it against a built-in golden model of DEPTH serial stages.
- Sequences NUM_VECTORS vectors, counts mismatches, records the first failing index and reports pass/done.

---
 rtl/xor_chain_checker.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/xor_chain_checker.sv
// Drives stimulus into an XOR/invert primitive chain and checks its output against a DEPTH-stage golden model.
// Optional build macro XOR_CHAIN_CHK_LFSR_STIM_EN selects 32-bit LFSR stimulus instead of the vector index.
module xor_chain_checker #(
    parameter int IO_PAIRS    = 10,
    parameter int DEPTH       = 1,
    parameter int NUM_VECTORS = 16,
    parameter int SETTLE      = 2,
    localparam int W  = 2 * IO_PAIRS,
    localparam int CW = $clog2(NUM_VECTORS + 1),
    localparam int IW = ($clog2(NUM_VECTORS) > 1) ? $clog2(NUM_VECTORS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [W-1:0]  dut_in,
    input  logic [W-1:0]  dut_out,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [CW-1:0] err_count,
    output logic          fail_valid,
    output logic [IW-1:0] fail_index
);

    localparam int SW = ($clog2(SETTLE + 1) > 1) ? $clog2(SETTLE + 1) : 1;
    localparam logic [IW-1:0] LAST_INDEX  = IW'(NUM_VECTORS - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } stateType;

    stateType      stateReg, stateNext;
    logic [W-1:0]  dutInReg, dutInNext;
    logic [CW-1:0] errReg, errNext;
    logic          failValidReg, failValidNext;
    logic [IW-1:0] failIndexReg, failIndexNext;
    logic [IW-1:0] indexReg, indexNext;
    logic [SW-1:0] settleReg, settleNext;
    logic          passReg, passNext;

    logic [W-1:0]  golden;
    logic          mismatch;
    logic [CW-1:0] errAfterCheck;
    logic [W-1:0]  firstVector;
    logic [W-1:0]  nextVector;

    // Golden model: each pair passes through DEPTH identical xor/invert stages.
    generate
        for (genvar gi = 0; gi < IO_PAIRS; gi++) begin : gPair
            logic b1;
            logic b0;
            always_comb begin
                b1 = dut_in[2*gi+1];
                b0 = dut_in[2*gi];
                for (int s = 0; s < DEPTH; s++) begin
                    b1 = b1 ^ b0;
                    b0 = ~b0;
                end
            end
            assign golden[2*gi+1] = b1;
            assign golden[2*gi]   = b0;
        end
    endgenerate

    assign mismatch      = (dut_out != golden);
    assign errAfterCheck = errReg + CW'(mismatch);

`ifdef XOR_CHAIN_CHK_LFSR_STIM_EN
    logic [31:0] lfsrReg, lfsrNext;

    function automatic logic [31:0] lfsrStep(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    // Low W bits of the LFSR, repeated when the bus is wider than 32.
    function automatic logic [W-1:0] lfsrVector(input logic [31:0] l);
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) begin
            v[i] = l[i % 32];
        end
        return v;
    endfunction

    assign firstVector = lfsrVector(32'h1);
    assign nextVector  = lfsrVector(lfsrStep(lfsrReg));
`else
    function automatic logic [W-1:0] indexVector(input logic [IW-1:0] idx);
        logic [W+IW-1:0] wide;
        wide = {{W{1'b0}}, idx};
        return wide[W-1:0];
    endfunction

    assign firstVector = '0;
    assign nextVector  = indexVector(indexReg + IW'(1));
`endif

    always_comb begin
        stateNext     = stateReg;
        dutInNext     = dutInReg;
        errNext       = errReg;
        failValidNext = failValidReg;
        failIndexNext = failIndexReg;
        indexNext     = indexReg;
        settleNext    = settleReg;
        passNext      = passReg;
`ifdef XOR_CHAIN_CHK_LFSR_STIM_EN
        lfsrNext      = lfsrReg;
`endif
        case (stateReg)
            IDLE, DONE: begin
                if (start) begin
                    stateNext     = DRIVE;
                    dutInNext     = firstVector;
                    errNext       = '0;
                    failValidNext = 1'b0;
                    failIndexNext = '0;
                    indexNext     = '0;
                    settleNext    = '0;
                    passNext      = 1'b0;
`ifdef XOR_CHAIN_CHK_LFSR_STIM_EN
                    lfsrNext      = 32'h1;
`endif
                end
            end
            DRIVE: begin
                settleNext = settleReg + SW'(1);
                if (settleReg == SETTLE_LAST) begin
                    stateNext = CHECK;
                end
            end
            CHECK: begin
                errNext = errAfterCheck;
                if (mismatch && !failValidReg) begin
                    failValidNext = 1'b1;
                    failIndexNext = indexReg;
                end
                if (indexReg == LAST_INDEX) begin
                    stateNext = DONE;
                    passNext  = (errAfterCheck == '0);
                end else begin
                    stateNext  = DRIVE;
                    indexNext  = indexReg + IW'(1);
                    settleNext = '0;
                    dutInNext  = nextVector;
`ifdef XOR_CHAIN_CHK_LFSR_STIM_EN
                    lfsrNext   = lfsrStep(lfsrReg);
`endif
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg     <= IDLE;
            dutInReg     <= '0;
            errReg       <= '0;
            failValidReg <= 1'b0;
            failIndexReg <= '0;
            indexReg     <= '0;
            settleReg    <= '0;
            passReg      <= 1'b0;
`ifdef XOR_CHAIN_CHK_LFSR_STIM_EN
            lfsrReg      <= 32'h1;
`endif
        end else begin
            stateReg     <= stateNext;
            dutInReg     <= dutInNext;
            errReg       <= errNext;
            failValidReg <= failValidNext;
            failIndexReg <= failIndexNext;
            indexReg     <= indexNext;
            settleReg    <= settleNext;
            passReg      <= passNext;
`ifdef XOR_CHAIN_CHK_LFSR_STIM_EN
            lfsrReg      <= lfsrNext;
`endif
        end
    end

    assign dut_in     = dutInReg;
    assign busy       = (stateReg == DRIVE) || (stateReg == CHECK);
    assign done       = (stateReg == DONE);
    assign pass       = passReg;
    assign err_count  = errReg;
    assign fail_valid = failValidReg;
    assign fail_index = failIndexReg;

endmodule
